// File: rtl/fifo_word_packer.sv
// Drains bytes from an upstream FIFO and packs them little-endian into words
// presented on a valid/ready handshake; flush emits a zero-padded partial word.
module fifo_word_packer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned CNT_WIDTH      = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 stack_empty,
  input  logic [DATA_WIDTH-1:0]                Data_in,
  output logic                                 read_from_stack,
  input  logic                                 flush,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_out,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic [CNT_WIDTH:0]                   word_bytes
);

  localparam int unsigned WORD_WIDTH = DATA_WIDTH * BYTES_PER_WORD;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(BYTES_PER_WORD - 1);
  localparam logic [CNT_WIDTH:0]   FULL_BYTES = (CNT_WIDTH + 1)'(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [WORD_WIDTH-1:0]   acc, acc_next;
  logic [CNT_WIDTH-1:0]    byte_idx, idx_next;
  logic [WORD_WIDTH-1:0]   word_out_next;
  logic [CNT_WIDTH:0]      word_bytes_next;
  logic                    word_valid_next;
  logic                    read_next;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      acc             <= '0;
      byte_idx        <= '0;
      word_out        <= '0;
      word_valid      <= 1'b0;
      word_bytes      <= '0;
      read_from_stack <= 1'b0;
    end else begin
      state           <= state_next;
      acc             <= acc_next;
      byte_idx        <= idx_next;
      word_out        <= word_out_next;
      word_valid      <= word_valid_next;
      word_bytes      <= word_bytes_next;
      read_from_stack <= read_next;
    end
  end

  // Next-state; outputs are registered copies of what the next state presents
  always_comb begin
    state_next      = state;
    acc_next        = acc;
    idx_next        = byte_idx;
    word_out_next   = word_out;
    word_bytes_next = word_bytes;

    unique case (state)
      IDLE: begin
        if (!stack_empty) begin
          state_next = REQ;
        end else if (flush && (byte_idx != '0)) begin
          state_next      = OUT;
          word_out_next   = acc;
          word_bytes_next = {1'b0, byte_idx};
        end
      end
      REQ: state_next = CAP;
      CAP: begin
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
          if (byte_idx == CNT_WIDTH'(i)) acc_next[i*DATA_WIDTH +: DATA_WIDTH] = Data_in;
        end
        // A full word holds byte_idx at the last lane; only the handshake clears it
        if (byte_idx == LAST_IDX) begin
          state_next      = OUT;
          word_out_next   = acc_next;
          word_bytes_next = FULL_BYTES;
        end else begin
          idx_next   = byte_idx + CNT_WIDTH'(1);
          state_next = stack_empty ? IDLE : REQ;
        end
      end
      OUT: begin
        if (word_ready) begin
          state_next      = IDLE;
          acc_next        = '0;
          idx_next        = '0;
          word_bytes_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    read_next       = (state_next == REQ);
    word_valid_next = (state_next == OUT);
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Randomised scoreboard bench for fifo_word_packer with a behavioural 4-entry FIFO upstream.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stack_empty;
  logic [7:0]  fifo_dout;
  logic        read_from_stack;
  logic        flush;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  word_bytes;

  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic [7:0]  fifo_q[$];
  int          fifo_cnt;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  n;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  pend[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_word;
  logic [2:0]  prev_bytes;

  fifo_word_packer #(.DATA_WIDTH(8), .BYTES_PER_WORD(4), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .stack_empty(stack_empty), .Data_in(fifo_dout),
    .read_from_stack(read_from_stack), .flush(flush), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .word_bytes(word_bytes)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered output on pop, shared synchronous reset
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_dout   <= 8'h00;
      stack_empty <= 1'b1;
      fifo_cnt    <= 0;
    end else begin
      if (read_from_stack && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      if (fifo_wr && fifo_q.size() < 4) fifo_q.push_back(fifo_wdata);
      stack_empty <= (fifo_q.size() == 0);
      fifo_cnt    <= fifo_q.size();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes accumulate in push order; every 4 make a word
  function automatic void ref_push(input logic [7:0] b);
    exp_t e;
    pend.push_back(b);
    if (pend.size() == 4) begin
      e.w = '0;
      for (int i = 0; i < 4; i++) e.w[i*8 +: 8] = pend[i];
      e.n = 3'd4;
      sb.push_back(e);
      pend.delete();
    end
  endfunction

  function automatic void ref_flush();
    exp_t e;
    e.w = '0;
    for (int i = 0; i < pend.size(); i++) e.w[i*8 +: 8] = pend[i];
    e.n = 3'(pend.size());
    sb.push_back(e);
    pend.delete();
  endfunction

  // Monitor: pops the scoreboard on every accepted word and watches protocol rules
  always @(negedge clk) begin
    if (!rst) begin
      if (read_from_stack) check("pop_while_empty", 32'(stack_empty), 32'd0);
      if (word_valid) check("pop_during_out", 32'(read_from_stack), 32'd0);
      if (word_valid && prev_hold) begin
        check("hold_word", word_out, prev_word);
        check("hold_bytes", 32'(word_bytes), 32'(prev_bytes));
      end
      if (word_valid && word_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", word_out, 32'hDEADDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word_out", word_out, e.w);
          check("word_bytes", 32'(word_bytes), 32'(e.n));
        end
      end
    end
    prev_hold  = word_valid && !word_ready && !rst;
    prev_word  = word_out;
    prev_bytes = word_bytes;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int guard = 0;
    while (fifo_cnt >= 4 && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check("push_timeout", 32'd1, 32'd0);
    fifo_wr    = 1'b1;
    fifo_wdata = b;
    ref_push(b);
    step();
    fifo_wr = 1'b0;
  endtask

  task automatic settle();
    int guard = 0;
    while ((fifo_cnt != 0 || !stack_empty) && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) check("drain_timeout", 32'd1, 32'd0);
    repeat (6) step();
  endtask

  task automatic do_flush();
    int guard = 0;
    ref_flush();
    flush = 1'b1;
    while (!word_valid && guard < 40) begin
      step();
      guard++;
    end
    if (guard >= 40) check("flush_timeout", 32'd1, 32'd0);
    flush = 1'b0;
  endtask

  task automatic wait_sb_empty();
    int guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      step();
      guard++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int guard;
    rst = 1'b1; flush = 1'b0; word_ready = 1'b1; fifo_wr = 1'b0; fifo_wdata = 8'h00;
    repeat (3) step();
    check("rst_word_out", word_out, 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_bytes", 32'(word_bytes), 32'd0);
    check("rst_read", 32'(read_from_stack), 32'd0);
    rst = 1'b0;
    step();

    // 1: one full word, latency of 9 cycles after the first byte lands
    fifo_wr = 1'b1; fifo_wdata = 8'h11; ref_push(8'h11);
    lat = 0;
    fork
      begin
        step(); fifo_wdata = 8'h22; ref_push(8'h22);
        step(); fifo_wdata = 8'h33; ref_push(8'h33);
        step(); fifo_wdata = 8'h44; ref_push(8'h44);
        step(); fifo_wr = 1'b0;
      end
      begin
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
          step();
          if (word_valid) begin
            lat = k;
            break;
          end
        end
      end
    join
    check("first_valid_latency", 32'(lat), 32'd9);
    step();
    check("valid_one_cycle", 32'(word_valid), 32'd0);
    wait_sb_empty();

    // 2: backpressure on the first of two words
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    guard = 0;
    while (!word_valid && guard < 100) begin step(); guard++; end
    check("bp_valid_seen", 32'(word_valid), 32'd1);
    repeat (5) step();
    check("bp_held_word", word_out, 32'h04030201);
    word_ready = 1'b1;
    wait_sb_empty();
    settle();

    // 3: partial word flushed
    push(8'hAA); push(8'hBB); push(8'hCC);
    settle();
    do_flush();
    wait_sb_empty();
    settle();

    // 4: flush with nothing pending is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_flush_valid", 32'(word_valid), 32'd0);
      check("idle_flush_read", 32'(read_from_stack), 32'd0);
      step();
    end

    // 5: reset mid-word discards the partial bytes
    push(8'h01); push(8'h02);
    step();
    rst = 1'b1;
    pend.delete();
    step();
    rst = 1'b0;
    step();
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    wait_sb_empty();
    settle();

    // 6: push lands in the same cycle as a pop of the single stored entry
    push(8'hA1);
    guard = 0;
    while (!read_from_stack && guard < 20) begin step(); guard++; end
    check("pop_seen", 32'(read_from_stack), 32'd1);
    push(8'hA2); push(8'hA3); push(8'hA4);
    wait_sb_empty();
    settle();

    // Random traffic with random backpressure and a final flush
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 150; i++) begin
        word_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 1 && fifo_cnt < 4) push(8'($urandom));
        else step();
      end
      word_ready = 1'b1;
      settle();
      if (pend.size() != 0) do_flush();
      wait_sb_empty();
      settle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
